// File: rtl/clk_gen_multi.sv
// rtl/clk_gen_multi.sv - multi-channel integer clock divider with shared lock sequencing
// Channels only run in ST_LOCKED, so every channel restarts phase-aligned after each (re)lock.
module clk_gen_multi #(
  parameter int NUM_CH      = 3,
  parameter int DIV_W       = 8,
  parameter int DIV_INIT    = 5,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                    i_sys_clk,
  input  logic                    i_rst_n,
  input  logic [NUM_CH*DIV_W-1:0] i_div_cfg,
  input  logic                    i_cfg_load,
  input  logic [NUM_CH-1:0]       i_ch_en,
  output logic [NUM_CH-1:0]       o_clk_out,
  output logic [NUM_CH-1:0]       o_clk_en,
  output logic                    o_locked
);

  localparam int               LCW       = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LCW-1:0]   LOCK_LAST = LCW'(LOCK_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_RST   = DIV_W'(DIV_INIT);

  typedef enum logic [1:0] {
    ST_RESET   = 2'd0,
    ST_LOCKING = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [LCW-1:0]     lock_cnt_q, lock_cnt_d;
  logic [DIV_W-1:0]   shadow_q [NUM_CH];
  logic [DIV_W-1:0]   shadow_d [NUM_CH];
  logic [DIV_W-1:0]   cnt_q    [NUM_CH];
  logic [DIV_W-1:0]   cnt_d    [NUM_CH];
  logic [DIV_W-1:0]   div_eff  [NUM_CH];
  logic [DIV_W-1:0]   high_len [NUM_CH];
  logic [NUM_CH-1:0]  run_q, run_d;
  logic [NUM_CH-1:0]  clk_out_q, clk_out_d;
  logic [NUM_CH-1:0]  clk_en_q, clk_en_d;
  logic               locked_q, locked_d;

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    for (int k = 0; k < NUM_CH; k++) begin
      shadow_d[k] = shadow_q[k];
    end
    case (state_q)
      ST_RESET: begin
        state_d    = ST_LOCKING;
        lock_cnt_d = '0;
      end
      ST_LOCKING: begin
        if (lock_cnt_q == LOCK_LAST) begin
          state_d = ST_LOCKED;
        end else begin
          lock_cnt_d = lock_cnt_q + LCW'(1);
        end
      end
      ST_LOCKED: begin
        state_d = ST_LOCKED;
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase
    // A reload always wins: capture, restart the settle count, stop every channel.
    if (i_cfg_load && (state_q != ST_RESET)) begin
      for (int k = 0; k < NUM_CH; k++) begin
        shadow_d[k] = i_div_cfg[k*DIV_W +: DIV_W];
      end
      lock_cnt_d = '0;
      state_d    = ST_LOCKING;
    end
  end

  always_comb begin
    locked_d = (state_d == ST_LOCKED);
    for (int k = 0; k < NUM_CH; k++) begin
      div_eff[k]  = (shadow_q[k] < DIV_W'(2)) ? DIV_W'(2) : shadow_q[k];
      high_len[k] = (div_eff[k] >> 1) + DIV_W'(div_eff[k][0]);
      run_d[k]    = locked_d && i_ch_en[k];
      cnt_d[k]    = '0;
      // A channel that was idle last cycle starts at phase 0 on this edge.
      if (run_d[k] && run_q[k]) begin
        cnt_d[k] = (cnt_q[k] == div_eff[k] - DIV_W'(1)) ? '0 : cnt_q[k] + DIV_W'(1);
      end
      clk_out_d[k] = run_d[k] && (cnt_d[k] < high_len[k]);
      clk_en_d[k]  = run_d[k] && (cnt_d[k] == '0);
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_RESET;
      lock_cnt_q <= '0;
      run_q      <= '0;
      clk_out_q  <= '0;
      clk_en_q   <= '0;
      locked_q   <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        shadow_q[k] <= DIV_RST;
        cnt_q[k]    <= '0;
      end
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      run_q      <= run_d;
      clk_out_q  <= clk_out_d;
      clk_en_q   <= clk_en_d;
      locked_q   <= locked_d;
      for (int k = 0; k < NUM_CH; k++) begin
        shadow_q[k] <= shadow_d[k];
        cnt_q[k]    <= cnt_d[k];
      end
    end
  end

  assign o_clk_out = clk_out_q;
  assign o_clk_en  = clk_en_q;
  assign o_locked  = locked_q;

endmodule

// File: tb/tb_clk_gen_multi.sv
// tb/tb_clk_gen_multi.sv - scoreboard bench for clk_gen_multi
module tb_clk_gen_multi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] div_cfg = '0;
  logic        cfg_load = 1'b0;
  logic [2:0]  ch_en = 3'b000;
  logic [2:0]  clk_out;
  logic [2:0]  clk_en;
  logic        locked;

  clk_gen_multi #(
    .NUM_CH(3), .DIV_W(8), .DIV_INIT(5), .LOCK_CYCLES(16)
  ) dut (
    .i_sys_clk (clk),
    .i_rst_n   (rst_n),
    .i_div_cfg (div_cfg),
    .i_cfg_load(cfg_load),
    .i_ch_en   (ch_en),
    .o_clk_out (clk_out),
    .o_clk_en  (clk_en),
    .o_locked  (locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       lk;
    logic [2:0] out;
    logic [2:0] en;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Expected-waveform state: edges left until lock (-1 = held in reset),
  // divide per channel, and cycles elapsed since each channel started.
  int   m_wait = -1;
  int   m_div[3] = '{5, 5, 5};
  int   m_age[3] = '{0, 0, 0};
  bit   m_on[3]  = '{0, 0, 0};

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, req);
    end
  endtask

  task automatic tick();
    exp_t e;
    int   d;
    if (!rst_n) begin
      m_wait = -1;
      for (int k = 0; k < 3; k++) m_div[k] = 5;
    end else if (m_wait < 0) begin
      m_wait = 16;
    end else if (cfg_load) begin
      m_wait = 16;
      for (int k = 0; k < 3; k++) m_div[k] = int'(div_cfg[k*8 +: 8]);
    end else if (m_wait > 0) begin
      m_wait--;
    end
    e.lk = (m_wait == 0);
    for (int k = 0; k < 3; k++) begin
      if (e.lk && ch_en[k]) begin
        m_age[k] = m_on[k] ? m_age[k] + 1 : 0;
        m_on[k]  = 1'b1;
      end else begin
        m_age[k] = 0;
        m_on[k]  = 1'b0;
      end
      d = (m_div[k] < 2) ? 2 : m_div[k];
      e.out[k] = m_on[k] && ((m_age[k] % d) < (d + 1) / 2);
      e.en[k]  = m_on[k] && ((m_age[k] % d) == 0);
    end
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("locked", {7'd0, locked}, {7'd0, e.lk});
        chk("clk_out", {5'd0, clk_out}, {5'd0, e.out});
        chk("clk_en", {5'd0, clk_en}, {5'd0, e.en});
      end
    end
  end

  initial begin : driver
    ch_en = 3'b111;
    #12;
    chk("rst_out", {5'd0, clk_out}, 8'd0);
    chk("rst_en", {5'd0, clk_en}, 8'd0);
    chk("rst_locked", {7'd0, locked}, 8'd0);
    ticks(2);
    rst_n = 1'b1;

    // Load on the very first edge out of reset must be ignored.
    div_cfg  = {8'd9, 8'd9, 8'd9};
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    ticks(15);
    chk("lock_edge16", {7'd0, locked}, 8'd0);
    tick();
    chk("lock_edge17", {7'd0, locked}, 8'd1);
    chk("lock_align_out", {5'd0, clk_out}, 8'h07);
    chk("lock_align_en", {5'd0, clk_en}, 8'h07);
    ticks(5);
    chk("default_period5", {5'd0, clk_en}, 8'h07);
    ticks(14);

    // Relock with clamped divides 0 and 1 plus divide 4.
    div_cfg  = {8'd1, 8'd0, 8'd4};
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    chk("reload_unlock", {7'd0, locked}, 8'd0);
    ticks(15);
    chk("relock_15", {7'd0, locked}, 8'd0);
    tick();
    chk("relock_16", {7'd0, locked}, 8'd1);
    ticks(12);

    // Odd and even divides: 7, 6, 3.
    div_cfg  = {8'd3, 8'd6, 8'd7};
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    ticks(16);
    ticks(1);
    // ch1 is now at phase 1 of 6, still high; drop it mid-high.
    ch_en = 3'b101;
    tick();
    chk("ch1_drop", {7'd0, clk_out[1]}, 8'd0);
    ticks(3);
    ch_en = 3'b111;
    tick();
    chk("ch1_restart_out", {7'd0, clk_out[1]}, 8'd1);
    chk("ch1_restart_en", {7'd0, clk_en[1]}, 8'd1);
    ticks(20);

    // Load and enable change on the same edge, then reload mid-lock at count 10.
    div_cfg  = {8'd2, 8'd5, 8'd9};
    cfg_load = 1'b1;
    ch_en    = 3'b101;
    tick();
    cfg_load = 1'b0;
    chk("same_edge_out", {5'd0, clk_out}, 8'd0);
    ticks(10);
    div_cfg  = {8'd2, 8'd5, 8'd8};
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    ticks(15);
    chk("midlock_15", {7'd0, locked}, 8'd0);
    tick();
    chk("midlock_16", {7'd0, locked}, 8'd1);
    chk("midlock_ch1_off", {7'd0, clk_out[1]}, 8'd0);
    ticks(18);

    // Asynchronous reset mid-period, then default divide restored.
    ch_en = 3'b111;
    ticks(3);
    rst_n = 1'b0;
    #1;
    chk("async_out", {5'd0, clk_out}, 8'd0);
    chk("async_en", {5'd0, clk_en}, 8'd0);
    chk("async_locked", {7'd0, locked}, 8'd0);
    #1;
    ticks(3);
    rst_n = 1'b1;
    ticks(17);
    chk("rearm_locked", {7'd0, locked}, 8'd1);
    ticks(5);
    chk("rearm_period5", {5'd0, clk_en}, 8'h07);
    ticks(10);

    chk("queue_drained", 8'(q.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
